// File: rtl/l2_access_arbiter_pkg.sv
// Shared encodings for the L2 port arbiter: FSM states, owner codes and enable levels.
package l2_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbIc   = 2'd1,
    ArbDc   = 2'd2,
    ArbGap  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIc = 1'b0,
    OwnDc = 1'b1
  } owner_e;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

endpackage

// File: rtl/l2_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie, the cache that did not own L2 last wins.
module l2_arb_rr_pick
  import l2_access_arbiter_pkg::*;
(
  input  logic   irq,
  input  logic   drq,
  input  owner_e last_grant,
  output owner_e pick,
  output logic   valid
);

  always_comb begin
    valid = irq | drq;
    if (irq && drq) begin
      pick = (last_grant == OwnIc) ? OwnDc : OwnIc;
    end else if (irq) begin
      pick = OwnIc;
    end else begin
      pick = OwnDc;
    end
  end

endmodule

// File: rtl/l2_access_arbiter.sv
// Grants the single L2 port to the I-cache or D-cache controller, one owner at a time.
// Optional grant timeout with arb_err pulse when L2_ARB_TIMEOUT_EN is defined.
module l2_access_arbiter
  import l2_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_rw,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic              l2_rdy,
  input  logic              complete,
  output logic              ic_en,
  output logic              dc_en,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rw,
  output logic              arb_busy,
  output logic              arb_err
);

  arb_state_e        state_q, state_d;
  owner_e            last_q, last_d;
  logic              ic_en_q, ic_en_d;
  logic              dc_en_q, dc_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  owner_e            pick;
  logic              pick_valid;
  logic              timeout;

  // l2_rdy carries no state-changing meaning for the arbiter.
  logic unused_l2_rdy;
  assign unused_l2_rdy = l2_rdy;

  l2_arb_rr_pick u_rr_pick (
    .irq        (irq),
    .drq        (drq),
    .last_grant (last_q),
    .pick       (pick),
    .valid      (pick_valid)
  );

`ifdef L2_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ArbIc || state_q == ArbDc) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    // Timeout release is the only path into the gap without complete or a dropped request.
    err_d = (state_d == ArbGap) && (state_q != ArbGap) && timeout && !complete &&
            ((state_q == ArbIc) ? irq : drq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          state_d = (pick == OwnIc) ? ArbIc : ArbDc;
          addr_d  = (pick == OwnIc) ? ic_addr : dc_addr;
          rw_d    = (pick == OwnIc) ? ic_rw : dc_rw;
        end
      end
      ArbIc: begin
        if (complete || !irq || timeout) begin
          state_d = ArbGap;
          last_d  = OwnIc;
        end
      end
      ArbDc: begin
        if (complete || !drq || timeout) begin
          state_d = ArbGap;
          last_d  = OwnDc;
        end
      end
      ArbGap: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
    ic_en_d = (state_d == ArbIc) ? Enable : Disable;
    dc_en_d = (state_d == ArbDc) ? Enable : Disable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      last_q  <= OwnDc;
      ic_en_q <= Disable;
      dc_en_q <= Disable;
      addr_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ic_en_q <= ic_en_d;
      dc_en_q <= dc_en_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
    end
  end

  assign ic_en    = ic_en_q;
  assign dc_en    = dc_en_q;
  assign l2_req   = ic_en_q | dc_en_q;
  assign arb_busy = ic_en_q | dc_en_q;
  assign l2_addr  = addr_q;
  assign l2_rw    = rw_q;

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed self-checking bench for l2_access_arbiter; build with L2_ARB_TIMEOUT_EN for the timeout test.
module tb_l2_access_arbiter;

  localparam int unsigned ADDR_W = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              irq, drq, ic_rw, dc_rw, l2_rdy, complete;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic              ic_en, dc_en, l2_req, l2_rw, arb_busy, arb_err;
  logic [ADDR_W-1:0] l2_addr;

  int checks = 0;
  int errors = 0;

  l2_access_arbiter #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .ic_addr  (ic_addr),
    .ic_rw    (ic_rw),
    .drq      (drq),
    .dc_addr  (dc_addr),
    .dc_rw    (dc_rw),
    .l2_rdy   (l2_rdy),
    .complete (complete),
    .ic_en    (ic_en),
    .dc_en    (dc_en),
    .l2_req   (l2_req),
    .l2_addr  (l2_addr),
    .l2_rw    (l2_rw),
    .arb_busy (arb_busy),
    .arb_err  (arb_err)
  );

  always #5 clk = ~clk;

  // One-hot grant must hold on every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (ic_en && dc_en) begin
        errors++;
        $display("FAIL onehot: ic_en=%0b dc_en=%0b required not both 1", ic_en, dc_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = 0; drq = 0; ic_rw = 0; dc_rw = 0; l2_rdy = 0; complete = 0;
    ic_addr = '0; dc_addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ic_en, dc_en, l2_req, arb_busy, arb_err, l2_rw} !== 6'b0 || l2_addr !== '0) begin
      errors++;
      $display("FAIL reset: en/req/busy/err/rw=%b addr=%h required all 0",
               {ic_en, dc_en, l2_req, arb_busy, arb_err, l2_rw}, l2_addr);
    end
  endtask

  task automatic test_single_ic();
    irq = 1; ic_addr = 28'h0000123; ic_rw = 1;
    tick();
    checks++;
    if ({ic_en, dc_en, l2_req, arb_busy, l2_rw} !== 5'b10111 || l2_addr !== 28'h0000123) begin
      errors++;
      $display("FAIL single_grant: en/req/busy/rw=%b addr=%h required 10111 addr 0000123",
               {ic_en, dc_en, l2_req, arb_busy, l2_rw}, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; irq = 0;
    checks++;
    if ({ic_en, dc_en, l2_req, arb_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: en/req/busy=%b required 0000", {ic_en, dc_en, l2_req, arb_busy});
    end
    tick();
    checks++;
    if ({ic_en, dc_en, arb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: en/busy=%b required 000", {ic_en, dc_en, arb_busy});
    end
  endtask

  task automatic test_tie();
    do_reset();
    irq = 1; drq = 1; ic_addr = 28'h0000010; dc_addr = 28'h0000020; ic_rw = 1; dc_rw = 0;
    tick();
    checks++;
    if ({ic_en, dc_en} !== 2'b10 || l2_addr !== 28'h0000010) begin
      errors++;
      $display("FAIL tie_first: ic/dc=%b addr=%h required 10 addr 0000010", {ic_en, dc_en}, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; irq = 0;
    tick();
    checks++;
    if ({ic_en, dc_en} !== 2'b00) begin
      errors++;
      $display("FAIL tie_gap: ic/dc=%b required 00 in idle after gap", {ic_en, dc_en});
    end
    tick();
    checks++;
    if ({ic_en, dc_en, l2_rw} !== 3'b010 || l2_addr !== 28'h0000020) begin
      errors++;
      $display("FAIL tie_second: ic/dc/rw=%b addr=%h required 010 addr 0000020",
               {ic_en, dc_en, l2_rw}, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; irq = 1;
    tick();
    tick();
    checks++;
    if ({ic_en, dc_en} !== 2'b10) begin
      errors++;
      $display("FAIL tie_repeat: ic/dc=%b required 10", {ic_en, dc_en});
    end
    complete = 1;
    tick();
    complete = 0; irq = 0; drq = 0;
    tick();
    tick();
  endtask

  task automatic test_contention();
    drq = 1; dc_addr = 28'h00000AA; dc_rw = 1;
    tick();
    checks++;
    if ({dc_en, l2_rw} !== 2'b11 || l2_addr !== 28'h00000AA) begin
      errors++;
      $display("FAIL cont_dc_grant: dc_en/rw=%b addr=%h required 11 addr 00000AA",
               {dc_en, l2_rw}, l2_addr);
    end
    irq = 1; ic_addr = 28'h0000055; ic_rw = 0; dc_addr = 28'h00000BB; l2_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ic_en, dc_en} !== 2'b01 || l2_addr !== 28'h00000AA) begin
        errors++;
        $display("FAIL cont_hold[%0d]: ic/dc=%b addr=%h required 01 addr 00000AA",
                 i, {ic_en, dc_en}, l2_addr);
      end
    end
    l2_rdy = 0; complete = 1;
    tick();
    complete = 0; drq = 0;
    checks++;
    if ({ic_en, dc_en} !== 2'b00) begin
      errors++;
      $display("FAIL cont_gap: ic/dc=%b required 00", {ic_en, dc_en});
    end
    tick();
    checks++;
    if (ic_en !== 1'b0) begin
      errors++;
      $display("FAIL cont_idle: ic_en=%b required 0", ic_en);
    end
    tick();
    checks++;
    if ({ic_en, l2_rw} !== 2'b10 || l2_addr !== 28'h0000055) begin
      errors++;
      $display("FAIL cont_ic_grant: ic_en/rw=%b addr=%h required 10 addr 0000055",
               {ic_en, l2_rw}, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; irq = 0;
    tick();
  endtask

  task automatic test_ignored_inputs();
    complete = 1; l2_rdy = 1;
    tick();
    tick();
    checks++;
    if ({ic_en, dc_en, arb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ignore: en/busy=%b required 000", {ic_en, dc_en, arb_busy});
    end
    complete = 0; l2_rdy = 0;
    irq = 1; ic_addr = 28'h0000777;
    tick();
    irq = 0;
    tick();
    checks++;
    if ({ic_en, arb_busy} !== 2'b00) begin
      errors++;
      $display("FAIL req_drop: ic_en/busy=%b required 00", {ic_en, arb_busy});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    irq = 1; ic_addr = 28'h0000321; ic_rw = 1;
    tick();
    rst = 1;
    tick();
    checks++;
    if ({ic_en, dc_en, l2_req, arb_busy, arb_err, l2_rw} !== 6'b0 || l2_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid: en/req/busy/err/rw=%b addr=%h required all 0",
               {ic_en, dc_en, l2_req, arb_busy, arb_err, l2_rw}, l2_addr);
    end
    rst = 0; irq = 0; drq = 1; dc_addr = 28'h0000444;
    tick();
    checks++;
    if ({ic_en, dc_en} !== 2'b01 || l2_addr !== 28'h0000444) begin
      errors++;
      $display("FAIL reset_then_dc: ic/dc=%b addr=%h required 01 addr 0000444",
               {ic_en, dc_en}, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; drq = 0;
    tick();
  endtask

`ifdef L2_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    irq = 1; drq = 1; ic_addr = 28'h0000001; dc_addr = 28'h0000002;
    tick();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({ic_en, arb_err} !== 2'b10) begin
        errors++;
        $display("FAIL to_granted[%0d]: ic_en/err=%b required 10", i, {ic_en, arb_err});
      end
      if (i < 8) tick();
    end
    tick();
    irq = 0;
    checks++;
    if ({ic_en, dc_en, arb_err} !== 3'b001) begin
      errors++;
      $display("FAIL to_abort: ic/dc/err=%b required 001", {ic_en, dc_en, arb_err});
    end
    tick();
    checks++;
    if ({dc_en, arb_err} !== 2'b00) begin
      errors++;
      $display("FAIL to_pulse: dc_en/err=%b required 00", {dc_en, arb_err});
    end
    tick();
    checks++;
    if ({dc_en, l2_addr} !== {1'b1, 28'h0000002}) begin
      errors++;
      $display("FAIL to_dc_grant: dc_en=%b addr=%h required 1 addr 0000002", dc_en, l2_addr);
    end
    complete = 1;
    tick();
    complete = 0; drq = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_ic();
    test_tie();
    test_contention();
    test_ignored_inputs();
    test_reset_mid();
`ifdef L2_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_access_arbiter.md
Name: l2_access_arbiter

Overview:
- Shares the single L2 cache port between the I-cache controller and the D-cache controller.
- Accepts one request per cache. Grants exactly one owner at a time through the per-cache enables (ic_en/dc_en), which the cache controllers already sample as "L2 available".
- Muxes the owner's address and rw onto L2 and holds ownership until the transaction's fill/writeback completes.
- Sits between both L1 controllers and the L2 cache/memory path.

Parameters:
- ADDR_W, 28, L2 block address width (word address bits [29:2]).
- TIMEOUT_CYC, 1023, max cycles a grant may stay open before forced release (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- irq  in  1  I-cache request; held high until its transaction completes
- ic_addr  in  ADDR_W  I-cache L2 block address
- ic_rw  in  1  I-cache read/write
- drq  in  1  D-cache request; held high until its transaction completes
- dc_addr  in  ADDR_W  D-cache L2 block address
- dc_rw  in  1  D-cache read/write
- l2_rdy  in  1  L2 has data/accepted write for current owner
- complete  in  1  owner's L1 write/fill finished; ends the transaction
- ic_en  out  1  grant to I-cache
- dc_en  out  1  grant to D-cache
- l2_req  out  1  valid request to L2
- l2_addr  out  ADDR_W  muxed address
- l2_rw  out  1  muxed rw
- arb_busy  out  1  a grant is open
- arb_err  out  1  timeout abort pulse (optional feature, else tied 0)

Behaviour:
- Reset (rst=1 at posedge):
  - state=ARB_IDLE; last_grant=DC, so IC wins the first tie.
  - ic_en=dc_en=l2_req=arb_busy=arb_err=0; l2_addr=0, l2_rw=0.
  - Reset mid-transaction drops the grant immediately. No completion is signalled.
- States: ARB_IDLE, ARB_IC, ARB_DC, ARB_GAP.
- ARB_IDLE:
  - Only irq -> ARB_IC. Only drq -> ARB_DC.
  - Both -> round-robin: grant the one not equal to last_grant.
  - Neither -> stay.
- Grant latency: a request seen in IDLE at edge N yields registered ic_en/dc_en=1 from cycle N+1.
- ARB_IC / ARB_DC:
  - Grant enable, l2_req=1, arb_busy=1.
  - l2_addr/l2_rw are registered from the owner at grant time and held constant for the whole grant.
  - On complete=1, or when the owner's request drops: update last_grant, go to ARB_GAP, deassert the enable next cycle.
- ARB_GAP:
  - One dead cycle, all enables 0, so the releasing controller can leave its L2 states. Then -> ARB_IDLE.
  - Minimum back-to-back turnaround is 2 idle cycles between grants.
- l2_rdy does not change state. It is ignored when no grant is open.
- Both enables high is illegal and must never occur (one-hot grant).
- A request arriving while the other cache owns L2 waits. Its controller sees its enable low and sits in its L2-busy wait state.
- complete with no grant open is ignored.
- If complete and a new request from the same owner coincide, the rule is release, then round-robin. The other cache, if waiting, wins next.

Optional Feature:
- Macro: L2_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on each grant and increments each cycle in ARB_IC/ARB_DC.
  - When it reaches TIMEOUT_CYC without complete: force ARB_GAP, pulse arb_err for one cycle, and update last_grant as a normal release.
- Undefined: no counter logic; arb_err tied 0; grants are unbounded.

Decomposition:
- Shared package/header icache.h-style include: state encodings ARB_IDLE/ARB_IC/ARB_DC/ARB_GAP, owner codes OWN_IC/OWN_DC, and ENABLE/DISABLE from stddef.h.
- One natural sub-module: l2_arb_rr_pick (combinational 2-way round-robin picker: irq, drq, last_grant -> pick, valid). The FSM, output registers and timeout counter stay in the top.

Test Plan:
- Single IC request: irq=1 with ic_addr=28'h0000123 -> ic_en=1, l2_addr=28'h0000123, l2_rw=ic_rw one cycle later. complete pulse -> ic_en=0 next cycle, ARB_GAP, then IDLE.
- Simultaneous requests after reset: irq=drq=1 -> IC granted first. After its complete, DC granted after the gap cycle. A repeated tie then goes to IC.
- Contention: DC owns L2; irq rises -> ic_en stays 0 until DC complete + gap; dc_en and ic_en are never simultaneously 1 (checked by assertion on every cycle).
- Address stability: change dc_addr from 28'h00000AA to 28'h00000BB mid-grant -> l2_addr stays 28'h00000AA until release.
- Reset mid-grant: rst=1 while ic_en=1 -> all outputs 0 next cycle; after rst=0 with drq=1 -> dc_en granted (last_grant reset to DC, so a tie favours IC).
- With L2_ARB_TIMEOUT_EN, TIMEOUT_CYC=8: grant IC and never assert complete -> ic_en drops after 8 granted cycles, arb_err pulses once, a pending drq is granted after the gap.
